sweep_monitor: RTL and testbench
================================

Name: sweep_monitor

Overview:
- Self-check stage directly downstream of the GPIO sweep generator; consumes its 34-bit pin bus and done pulse on the same clock.
- Verifies in silicon that pins go high one at a time, in order 0..33, each for the programmed dwell, then done.
- Reports sticky pass/fail, error code and the failing pin; counts passed sweeps.

Parameters:
- NUM_PINS, 34, width of monitored bus
- CLKS_PER_MS, 10000, clock cycles per prescaler unit
- TOL, 2, allowed dwell deviation in cycles (±)
- DONE_WIN, 16, max cycles from last pin falling to done_in

Ports:
- clk  input  1  system clock (10 MHz)
- nrst  input  1  asynchronous active-low reset
- clear  input  1  synchronous return to IDLE, clears status
- arm  input  1  start watching for a sweep (pulse)
- prescaler  input  14  same dwell setting given to the generator, in ms
- gpio_in  input  NUM_PINS  generator pin bus
- done_in  input  1  generator done pulse
- busy  output  1  high in WAIT_START/TRACK/DRAIN
- pass  output  1  sticky sweep-passed flag
- fail  output  1  sticky sweep-failed flag
- err_code  output  3  error cause, valid while fail
- err_pin  output  6  expected pin index at failure
- sweep_count  output  8  passed sweeps, saturating

Behaviour:
- Reset (async, nrst=0): state IDLE; busy, pass, fail, err_code, err_pin, sweep_count all 0.
- Priority per cycle: clear > arm > state logic. clear: IDLE, pass/fail/err cleared, sweep_count kept.
- IDLE/PASS/FAIL + arm: exp_dwell = {14'd0,prescaler} * CLKS_PER_MS (28-bit), clear pass/fail → WAIT_START. prescaler==0 → FAIL, ERR_CFG, next cycle.
- WAIT_START: gpio_in==0 → stay; ==bit0 → TRACK, idx=0, dwell=1; multi-bit → FAIL ERR_ONEHOT; other single bit → FAIL ERR_ORDER; done_in → FAIL ERR_DONE.
- TRACK, each cycle, gpio_in classified by sub-module:
  - equals 1<<idx: dwell++ (28-bit, saturating); dwell > exp_dwell+TOL → FAIL ERR_LONG.
  - equals 1<<(idx+1), idx<NUM_PINS-1: dwell < exp_dwell-TOL → FAIL ERR_SHORT, else idx++, dwell=1.
  - zero with idx==NUM_PINS-1: dwell check as above, then DRAIN, win=0.
  - zero with idx<NUM_PINS-1 → ERR_GAP; multi-bit → ERR_ONEHOT; other single bit → ERR_ORDER; done_in → ERR_DONE.
- exp_dwell-TOL clamps at 0.
- DRAIN:
  - done_in → PASS, sweep_count++ (saturate 255).
  - Any gpio_in bit → FAIL ERR_ORDER.
  - win reaches DONE_WIN without done → FAIL ERR_DONE.
  - done_in in the same cycle as the last-pin fall is accepted.
- pass/fail/err update one cycle after the offending/completing sample (registered); err_pin = idx at that sample.
- Errors: 0 NONE, 1 ORDER, 2 ONEHOT, 3 GAP, 4 SHORT, 5 LONG, 6 DONE, 7 CFG.
- arm while busy is ignored.
- nrst mid-sweep: immediate IDLE; the next sweep needs a new arm.

Optional Feature:
- SWEEP_MON_TIMING_EN defined: dwell checks ERR_SHORT/ERR_LONG active; prescaler==0 gives ERR_CFG.
- Undefined: dwell counter and exp_dwell multiplier are not built; only order, one-hot, gap and done are checked; prescaler is ignored and codes 4, 5, 7 never occur.

Decomposition:
- Package sweep_mon_pkg: state_t enum (IDLE, WAIT_START, TRACK, DRAIN, PASS, FAIL), err_t enum (3-bit codes above), DWELL_W=28 constant.
- One sub-module, onehot_classify: combinational; gpio_in → is_zero, is_multi, index[5:0].

Test Plan:
- CLKS_PER_MS=4, prescaler=2 (dwell 8), ideal sweep 0..33 each 8 cycles, done 3 cycles after last fall → pass=1, err_code=0, sweep_count=1.
- Same, pin 5 skipped (4→6) → fail, err_code=1, err_pin=5.
- Pin 12 held 11 cycles (timing on) → fail, err_code=5, err_pin=12; pin 12 held 5 cycles → err_code=4.
- Bits 3 and 4 high together → fail, err_code=2, err_pin=3; bus 0 mid-sweep at idx 20 → err_code=3, err_pin=20.
- No done within 16 cycles after pin 33 falls → fail, err_code=6, err_pin=33.
- arm with prescaler=0 → fail, err_code=7 next cycle; nrst pulsed mid-TRACK → all outputs 0, state IDLE; 256 passes → sweep_count stays 255.

Source files
------------

// File: rtl/sweep_mon_pkg.sv
// sweep_mon_pkg: shared state/error encodings and dwell width for sweep_monitor
package sweep_mon_pkg;
    localparam int DWELL_W = 28;
    typedef enum logic [2:0] {IDLE, WAIT_START, TRACK, DRAIN, PASS, FAIL} state_t;
    typedef enum logic [2:0] {
        ERR_NONE, ERR_ORDER, ERR_ONEHOT, ERR_GAP, ERR_SHORT, ERR_LONG, ERR_DONE, ERR_CFG
    } err_t;
endpackage

// File: rtl/sweep_monitor_onehot_classify.sv
// onehot_classify: combinational classification of the monitored pin bus
// ports: gpio_in (bus) -> is_zero (no bit set), is_multi (two or more bits set),
//        index (position of the highest set bit; exact when a single bit is set)
module onehot_classify #(
    parameter int NUM_PINS = 34
)(
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic                is_zero,
    output logic                is_multi,
    output logic [5:0]          index
);
    assign is_zero  = gpio_in == '0;
    assign is_multi = (gpio_in & (gpio_in - NUM_PINS'(1))) != '0;
    always_comb begin
        index = '0;
        for (int i = 0; i < NUM_PINS; i++)
            if (gpio_in[i]) index = 6'(i);
    end
endmodule

// File: rtl/sweep_monitor.sv
// sweep_monitor: checks that the GPIO sweep raises pins one at a time, in order, then signals done
// ports: clk, nrst (async active-low), clear (sync return to IDLE), arm (start pulse),
//        prescaler (dwell in ms), gpio_in (pin bus), done_in (generator done pulse)
//        -> busy, sticky pass/fail, err_code, err_pin (expected pin at failure), sweep_count
// SWEEP_MON_TIMING_EN: when defined, dwell length is checked (SHORT/LONG) and prescaler==0 is a CFG error
module sweep_monitor
    import sweep_mon_pkg::*;
#(
    parameter int NUM_PINS    = 34,
    parameter int CLKS_PER_MS = 10000,
    parameter int TOL         = 2,
    parameter int DONE_WIN    = 16
)(
    input  logic                clk,
    input  logic                nrst,
    input  logic                clear,
    input  logic                arm,
    input  logic [13:0]         prescaler,
    input  logic [NUM_PINS-1:0] gpio_in,
    input  logic                done_in,
    output logic                busy,
    output logic                pass,
    output logic                fail,
    output logic [2:0]          err_code,
    output logic [5:0]          err_pin,
    output logic [7:0]          sweep_count
);
    localparam int WIN_W = $clog2(DONE_WIN + 1);
    localparam logic [5:0] LAST = 6'(NUM_PINS - 1);
    state_t state;
    err_t err_now;
    logic [5:0] idx, index, pin_now;
    logic [WIN_W-1:0] win;
    logic is_zero, is_multi, too_short, too_long, cfg_bad;
    logic go_track, go_next, go_drain, go_pass;
    onehot_classify #(.NUM_PINS(NUM_PINS)) u_cls (
        .gpio_in (gpio_in),
        .is_zero (is_zero),
        .is_multi(is_multi),
        .index   (index)
    );
`ifdef SWEEP_MON_TIMING_EN
    logic [DWELL_W-1:0] dwell, exp_dwell, dwell_inc, lo_lim, hi_lim;
    assign dwell_inc = &dwell ? dwell : dwell + DWELL_W'(1);
    assign hi_lim    = exp_dwell + DWELL_W'(TOL);
    assign lo_lim    = exp_dwell > DWELL_W'(TOL) ? exp_dwell - DWELL_W'(TOL) : '0;
    assign too_long  = dwell_inc > hi_lim;
    assign too_short = dwell < lo_lim;
    assign cfg_bad   = prescaler == '0;
`else
    logic unused_cfg;
    assign unused_cfg = ^{prescaler, CLKS_PER_MS[0], TOL[0]};
    assign too_long   = 1'b0;
    assign too_short  = 1'b0;
    assign cfg_bad    = 1'b0;
`endif
    assign busy = state inside {WAIT_START, TRACK, DRAIN};
    always_comb begin
        err_now  = ERR_NONE;
        pin_now  = idx;
        go_track = 1'b0;
        go_next  = 1'b0;
        go_drain = 1'b0;
        go_pass  = 1'b0;
        case (state)
            WAIT_START: begin
                pin_now = '0;
                if (done_in) err_now = ERR_DONE;
                else if (is_multi) err_now = ERR_ONEHOT;
                else if (!is_zero) begin
                    if (index == '0) go_track = 1'b1;
                    else err_now = ERR_ORDER;
                end
            end
            TRACK: begin
                // done together with the last pin falling is a legal early finish
                if (done_in && !(is_zero && idx == LAST)) err_now = ERR_DONE;
                else if (is_zero) begin
                    if (idx != LAST) err_now = ERR_GAP;
                    else if (too_short) err_now = ERR_SHORT;
                    else if (done_in) go_pass = 1'b1;
                    else go_drain = 1'b1;
                end
                else if (is_multi) err_now = ERR_ONEHOT;
                else if (index == idx) err_now = too_long ? ERR_LONG : ERR_NONE;
                else if (idx != LAST && index == idx + 6'd1) begin
                    if (too_short) err_now = ERR_SHORT;
                    else go_next = 1'b1;
                end
                else begin
                    err_now = ERR_ORDER;
                    pin_now = idx == LAST ? idx : idx + 6'd1;
                end
            end
            DRAIN: begin
                if (done_in) go_pass = 1'b1;
                else if (!is_zero) err_now = ERR_ORDER;
                else if (win == WIN_W'(DONE_WIN - 1)) err_now = ERR_DONE;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            idx         <= '0;
            win         <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            err_code    <= ERR_NONE;
            err_pin     <= '0;
            sweep_count <= '0;
`ifdef SWEEP_MON_TIMING_EN
            dwell       <= '0;
            exp_dwell   <= '0;
`endif
        end else if (clear) begin
            state    <= IDLE;
            pass     <= 1'b0;
            fail     <= 1'b0;
            err_code <= ERR_NONE;
            err_pin  <= '0;
        end else if (arm && !busy) begin
            state    <= cfg_bad ? FAIL : WAIT_START;
            pass     <= 1'b0;
            fail     <= cfg_bad;
            err_code <= cfg_bad ? ERR_CFG : ERR_NONE;
            err_pin  <= '0;
            idx      <= '0;
`ifdef SWEEP_MON_TIMING_EN
            exp_dwell <= {14'd0, prescaler} * DWELL_W'(CLKS_PER_MS);
`endif
        end else begin
            if (err_now != ERR_NONE) begin
                state    <= FAIL;
                fail     <= 1'b1;
                err_code <= err_now;
                err_pin  <= pin_now;
            end else if (go_pass) begin
                state       <= PASS;
                pass        <= 1'b1;
                sweep_count <= sweep_count + {7'd0, ~&sweep_count};
            end else if (go_drain) begin
                state <= DRAIN;
                win   <= '0;
            end else if (go_track) begin
                state <= TRACK;
                idx   <= '0;
            end else if (go_next) begin
                idx <= idx + 6'd1;
            end else if (state == DRAIN) begin
                win <= win + WIN_W'(1);
            end
`ifdef SWEEP_MON_TIMING_EN
            dwell <= (go_track || go_next) ? DWELL_W'(1) : dwell_inc;
`endif
        end
    end
endmodule

// File: tb/tb_sweep_monitor.sv
// tb_sweep_monitor: directed sweeps checked every cycle against a stream-level verdict model
module tb_sweep_monitor;
    localparam int CPM = 4, TOL = 2, DWIN = 16, MAXL = 1024;
    logic clk = 1'b0, nrst = 1'b1, clear = 1'b0, arm = 1'b0, done_in = 1'b0;
    logic [13:0] prescaler = 14'd2;
    logic [33:0] gpio_in = '0;
    logic busy, pass, fail;
    logic [2:0] err_code;
    logic [5:0] err_pin;
    logic [7:0] sweep_count;
    sweep_monitor #(.NUM_PINS(34), .CLKS_PER_MS(CPM), .TOL(TOL), .DONE_WIN(DWIN)) dut (
        .clk(clk), .nrst(nrst), .clear(clear), .arm(arm), .prescaler(prescaler),
        .gpio_in(gpio_in), .done_in(done_in), .busy(busy), .pass(pass), .fail(fail),
        .err_code(err_code), .err_pin(err_pin), .sweep_count(sweep_count)
    );
    always #5 clk = ~clk;
    int tests = 0, fails = 0, wp = 0;
    logic [33:0] gs [MAXL];
    bit ds [MAXL];
    bit chk = 0, tm = 0, e_busy = 0, e_pass = 0, e_fail = 0;
    int e_err = 0, e_pin = 0, e_cnt = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (chk) begin
        check("busy", busy, e_busy);
        check("pass", pass, e_pass);
        check("fail", fail, e_fail);
        check("sweep_count", sweep_count, e_cnt);
        if (e_fail) begin
            check("err_code", err_code, e_err);
            check("err_pin", err_pin, e_pin);
        end
    end
    task automatic clr_s();
        for (int i = 0; i < MAXL; i++) begin gs[i] = '0; ds[i] = 0; end
        wp = 0;
    endtask
    task automatic put(input logic [33:0] v, input int n);
        for (int i = 0; i < n; i++) begin gs[wp] = v; wp++; end
    endtask
    task automatic pins(input int a, input int b, input int dur);
        for (int p = a; p <= b; p++) put(34'd1 << p, dur);
    endtask
    task automatic done_after(input int k);
        put('0, k);
        ds[wp] = 1;
        put('0, 1);
    endtask
    // Scans the stream as runs of one-hot values and finds the first sample that decides the sweep.
    function automatic void predict(input int presc, output int kv, output bit vp, output int ve, output int vpin);
        int i, j, len, lo, hi;
        hi = presc * CPM + TOL;
        lo = presc * CPM > TOL ? presc * CPM - TOL : 0;
        vp = 0; ve = 0; vpin = 0; i = 0;
        while (i < MAXL - 40 && gs[i] == '0 && !ds[i]) i++;
        kv = i;
        if (ds[i]) begin ve = 6; return; end
        if (gs[i] != 34'd1) begin ve = $countones(gs[i]) > 1 ? 2 : 1; return; end
        for (int p = 0; p < 34; p++) begin
            j = i + 1;
            while (j < MAXL - 20 && gs[j] == gs[i] && !ds[j]) begin
                if (tm && j - i + 1 > hi) begin kv = j; ve = 5; vpin = p; return; end
                j++;
            end
            kv = j; vpin = p; len = j - i;
            if (ds[j] && !(gs[j] == '0 && p == 33)) begin ve = 6; return; end
            if (gs[j] == '0 && p < 33) begin ve = 3; return; end
            if ($countones(gs[j]) > 1) begin ve = 2; return; end
            if (!(gs[j] == '0 || (p < 33 && gs[j] == (34'd1 << (p + 1))))) begin
                ve = 1; vpin = p < 33 ? p + 1 : 33; return;
            end
            if (tm && len < lo) begin ve = 4; return; end
            i = j;
        end
        if (ds[i]) begin vp = 1; return; end
        for (int m = 1; m <= DWIN; m++) begin
            kv = i + m;
            if (ds[kv]) begin vp = 1; return; end
            if (gs[kv] != '0) begin ve = 1; return; end
        end
        ve = 6;
    endfunction
    task automatic run(input int presc, input int arm_at = -1);
        int kv, ve, vpin;
        bit vp;
        prescaler = 14'(presc);
        arm = 1;
        @(posedge clk); #1;
        arm = 0;
        e_busy = 1; e_pass = 0; e_fail = 0;
        if (tm && presc == 0) begin
            e_busy = 0; e_fail = 1; e_err = 7; e_pin = 0;
            @(negedge clk);
            return;
        end
        predict(presc, kv, vp, ve, vpin);
        for (int k = 0; k <= kv; k++) begin
            gpio_in = gs[k]; done_in = ds[k]; arm = (k == arm_at);
            @(posedge clk); #1;
            if (k == kv) begin
                e_busy = 0; e_pass = vp; e_fail = !vp; e_err = ve; e_pin = vpin;
                if (vp && e_cnt < 255) e_cnt++;
            end
        end
        gpio_in = '0; done_in = 0; arm = 0;
        @(negedge clk);
    endtask
    task automatic ideal(input int dur, input int dly);
        clr_s(); put('0, 2); pins(0, 33, dur); done_after(dly);
    endtask
    initial begin
`ifdef SWEEP_MON_TIMING_EN
        tm = 1;
`endif
        #2 nrst = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0); check("rst_pass", pass, 0); check("rst_fail", fail, 0);
        check("rst_err", err_code, 0); check("rst_pin", err_pin, 0); check("rst_cnt", sweep_count, 0);
        @(negedge clk); nrst = 1; chk = 1;
        ideal(8, 3); run(2, 10);
        check("ideal_pass", pass, 1); check("ideal_err", err_code, 0); check("ideal_cnt", sweep_count, 1);
        clr_s(); put('0, 2); pins(0, 4, 8); pins(6, 33, 8); done_after(3); run(2);
        check("skip_code", err_code, 1); check("skip_pin", err_pin, 5);
        clr_s(); put('0, 2); pins(0, 11, 8); pins(12, 12, 11); pins(13, 33, 8); done_after(3); run(2);
        if (tm) begin check("long_code", err_code, 5); check("long_pin", err_pin, 12); end
        else check("long_untimed_pass", pass, 1);
        clr_s(); put('0, 2); pins(0, 11, 8); pins(12, 12, 5); pins(13, 33, 8); done_after(3); run(2);
        if (tm) begin check("short_code", err_code, 4); check("short_pin", err_pin, 12); end
        else check("short_untimed_pass", pass, 1);
        clr_s(); put('0, 2); pins(0, 2, 8); put(34'd1 << 3, 4); put(34'h18, 3); run(2);
        check("onehot_code", err_code, 2); check("onehot_pin", err_pin, 3);
        clr_s(); put('0, 2); pins(0, 20, 8); put('0, 5); run(2);
        check("gap_code", err_code, 3); check("gap_pin", err_pin, 20);
        clr_s(); put('0, 2); pins(0, 33, 8); put('0, 30); run(2);
        check("nodone_code", err_code, 6); check("nodone_pin", err_pin, 33);
        ideal(8, 16); run(2);
        check("done_at_win_pass", pass, 1);
        ideal(8, 0); run(2);
        check("done_same_cycle_pass", pass, 1);
        clr_s(); put('0, 3); pins(0, 33, 2); put(34'd1, 1); run(1);
        check("drain_order_code", err_code, 1);
        ideal(8, 3); run(0);
        if (tm) check("cfg_code", err_code, 7);
        else check("cfg_untimed_pass", pass, 1);
        ideal(8, 3);
        prescaler = 14'd2; arm = 1;
        @(posedge clk); #1;
        arm = 0; e_busy = 1; e_pass = 0; e_fail = 0;
        for (int k = 0; k < 40; k++) begin gpio_in = gs[k]; @(posedge clk); #1; end
        nrst = 0;
        e_busy = 0; e_pass = 0; e_fail = 0; e_cnt = 0;
        #1;
        check("midrst_busy", busy, 0); check("midrst_pass", pass, 0); check("midrst_fail", fail, 0);
        check("midrst_err", err_code, 0); check("midrst_pin", err_pin, 0); check("midrst_cnt", sweep_count, 0);
        @(negedge clk); @(negedge clk); nrst = 1;
        for (int k = 40; k < 80; k++) begin gpio_in = gs[k]; @(posedge clk); #1; end
        gpio_in = '0;
        @(negedge clk);
        for (int n = 0; n < 256; n++) begin
            clr_s(); put('0, 1); pins(0, 33, 2); done_after(1); run(1);
        end
        check("sat_cnt", sweep_count, 255);
        clr_s(); put('0, 2); done_after(0); run(2);
        check("wait_done_code", err_code, 6); check("wait_done_pin", err_pin, 0);
        clear = 1;
        @(posedge clk); #1;
        clear = 0; e_fail = 0; e_pass = 0; e_busy = 0;
        @(negedge clk);
        check("clear_fail", fail, 0); check("clear_cnt", sweep_count, 255);
        chk = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
